// File: rtl/mat_pkg.sv
// Shared types and arithmetic helpers for the sequential matrix multiplier.
// Saturating narrowing is selected with the MULTIPLY_MAT_SAT_EN macro; wrap otherwise.
package mat_pkg;

    typedef logic [21:0] reading_t;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        COMPUTE = 2'd2,
        OUTPUT  = 2'd3
    } mat_state_t;

    // Wide enough to hold any sign-extended accumulator this block can build.
    localparam int NARROW_W = 256;

    function automatic int acc_width(input int data_w, input int size_b);
        return 2 * data_w + $clog2(size_b) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic in_range(input logic signed [NARROW_W-1:0] v, input int out_w);
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        hi = (NARROW_W'(1'b1) <<< (out_w - 1)) - NARROW_W'(1'b1);
        lo = ~hi;
        return (v <= hi) && (v >= lo);
    endfunction

    // Result is meaningful in its low out_w bits; callers truncate.
    function automatic logic [NARROW_W-1:0] narrow(input logic signed [NARROW_W-1:0] v, input int out_w);
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        hi = (NARROW_W'(1'b1) <<< (out_w - 1)) - NARROW_W'(1'b1);
        lo = ~hi;
`ifdef MULTIPLY_MAT_SAT_EN
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
`else
        return v & ((NARROW_W'(1'b1) << out_w) - NARROW_W'(1'b1));
`endif
    endfunction

endpackage

// File: rtl/mat_mac.sv
// Signed multiply-accumulate register; sum_o exposes the value the next enabled edge stores.
module mat_mac
    import mat_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 68
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  sum_o
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod_s = a_i * b_i;
    assign sum_o  = acc_q + {{(ACC_W - 2*DATA_W){prod_s[2*DATA_W-1]}}, prod_s};

    // Accumulator register: clear has priority over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= {ACC_W{1'b0}};
        end else if (clr_i) begin
            acc_q <= {ACC_W{1'b0}};
        end else if (en_i) begin
            acc_q <= sum_o;
        end else begin
            acc_q <= acc_q;
        end
    end

endmodule

// File: rtl/multiply_mat_seq.sv
// Sequential C = A x B: streams A then B in, one MAC per cycle, streams C out row-major.
// Define MULTIPLY_MAT_SAT_EN to saturate out-of-range results instead of wrapping.
module multiply_mat_seq
    import mat_pkg::*;
#(
    parameter int SIZE_A    = 8,
    parameter int SIZE_B    = 8,
    parameter int SIZE_C    = 8,
    parameter int DATA_W    = 32,
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     ovf
);

    localparam int ACC_W = acc_width(DATA_W, SIZE_B);
    localparam int NA    = SIZE_A * SIZE_B;
    localparam int NB    = SIZE_B * SIZE_C;
    localparam int A_IW  = idx_width(NA);
    localparam int B_IW  = idx_width(NB);
    localparam int CNT_W = idx_width((NA > NB) ? NA : NB);
    localparam int I_W   = idx_width(SIZE_A);
    localparam int J_W   = idx_width(SIZE_C);
    localparam int K_W   = idx_width(SIZE_B);

    mat_state_t              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [I_W-1:0]          i_q;
    logic [J_W-1:0]          j_q;
    logic [K_W-1:0]          k_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    ovf_q;

    logic signed [DATA_W-1:0] a_buf_q [NA];
    logic signed [DATA_W-1:0] b_buf_q [NB];

    logic                       in_xfer_s;
    logic [A_IW-1:0]            a_idx_s;
    logic [B_IW-1:0]            b_idx_s;
    logic signed [ACC_W-1:0]    sum_s;
    logic signed [ACC_W-1:0]    scaled_s;
    logic signed [NARROW_W-1:0] wide_s;
    logic                       k_last_s;
    logic                       elem_last_s;

    assign in_xfer_s = in_valid && in_ready_q;

    // Operand addressing and end-of-row/end-of-matrix decode.
    always_comb begin
        a_idx_s     = A_IW'(int'(i_q) * SIZE_B + int'(k_q));
        b_idx_s     = B_IW'(int'(k_q) * SIZE_C + int'(j_q));
        k_last_s    = (k_q == K_W'(SIZE_B - 1));
        elem_last_s = (i_q == I_W'(SIZE_A - 1)) && (j_q == J_W'(SIZE_C - 1));
        scaled_s    = sum_s >>> FRAC_BITS;
        wide_s      = NARROW_W'(scaled_s);
    end

    // Operand buffers hold no reset: their contents are irrelevant until loaded.
    always_ff @(posedge clk) begin
        if (in_xfer_s && (state_q == LOAD_A)) begin
            a_buf_q[A_IW'(cnt_q)] <= in_data;
        end
        if (in_xfer_s && (state_q == LOAD_B)) begin
            b_buf_q[B_IW'(cnt_q)] <= in_data;
        end
    end

    mat_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != COMPUTE),
        .en_i  (state_q == COMPUTE),
        .a_i   (a_buf_q[a_idx_s]),
        .b_i   (b_buf_q[b_idx_s]),
        .sum_o (sum_s)
    );

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            cnt_q       <= {CNT_W{1'b0}};
            i_q         <= {I_W{1'b0}};
            j_q         <= {J_W{1'b0}};
            k_q         <= {K_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_W{1'b0}};
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (in_xfer_s) begin
                        busy_q <= 1'b1;
                        if (cnt_q == {CNT_W{1'b0}}) begin
                            ovf_q <= 1'b0;
                        end
                        if (cnt_q == CNT_W'(NA - 1)) begin
                            cnt_q   <= {CNT_W{1'b0}};
                            state_q <= LOAD_B;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1'b1);
                        end
                    end
                end
                LOAD_B: begin
                    // in_ready drops after the last B element; the following edge starts COMPUTE.
                    if (in_xfer_s) begin
                        if (cnt_q == CNT_W'(NB - 1)) begin
                            cnt_q      <= {CNT_W{1'b0}};
                            in_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1'b1);
                        end
                    end else if (!in_ready_q) begin
                        state_q <= COMPUTE;
                        i_q     <= {I_W{1'b0}};
                        j_q     <= {J_W{1'b0}};
                        k_q     <= {K_W{1'b0}};
                    end
                end
                COMPUTE: begin
                    if (k_last_s) begin
                        k_q         <= {K_W{1'b0}};
                        state_q     <= OUTPUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= OUT_W'(narrow(wide_s, OUT_W));
                        out_last_q  <= elem_last_s;
                        if (!in_range(wide_s, OUT_W)) begin
                            ovf_q <= 1'b1;
                        end
                    end else begin
                        k_q <= k_q + K_W'(1'b1);
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (out_last_q) begin
                            state_q    <= LOAD_A;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q <= COMPUTE;
                            if (j_q == J_W'(SIZE_C - 1)) begin
                                j_q <= {J_W{1'b0}};
                                i_q <= i_q + I_W'(1'b1);
                            end else begin
                                j_q <= j_q + J_W'(1'b1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiply_mat_seq.sv
// Directed bench: 2x2x2 jobs, mid-job reset, back-to-back jobs, overflow and fractional rescale.
module tb_multiply_mat_seq;

    logic clk;
    logic rst_n;

    logic               in_valid, in_ready, out_valid, out_ready, out_last, busy, ovf;
    logic signed [31:0] in_data, out_data;

    logic              d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready, d2_out_last, d2_busy, d2_ovf;
    logic signed [7:0] d2_in_data, d2_out_data;

    logic               d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready, d3_out_last, d3_busy, d3_ovf;
    logic signed [15:0] d3_in_data, d3_out_data;

    int checks;
    int errors;
    int job_in [8];
    int job_exp [4];

    multiply_mat_seq #(.SIZE_A(2), .SIZE_B(2), .SIZE_C(2), .DATA_W(32), .OUT_W(32), .FRAC_BITS(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .ovf(ovf));

    multiply_mat_seq #(.SIZE_A(1), .SIZE_B(2), .SIZE_C(1), .DATA_W(8), .OUT_W(8), .FRAC_BITS(0)) dut_ovf (
        .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready), .in_data(d2_in_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_data(d2_out_data), .out_last(d2_out_last),
        .busy(d2_busy), .ovf(d2_ovf));

    multiply_mat_seq #(.SIZE_A(1), .SIZE_B(1), .SIZE_C(1), .DATA_W(16), .OUT_W(16), .FRAC_BITS(4)) dut_frac (
        .clk(clk), .rst_n(rst_n), .in_valid(d3_in_valid), .in_ready(d3_in_ready), .in_data(d3_in_data),
        .out_valid(d3_out_valid), .out_ready(d3_out_ready), .out_data(d3_out_data), .out_last(d3_out_last),
        .busy(d3_busy), .ovf(d3_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int v);
        int n;
        in_valid = 1'b1;
        in_data  = v;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("push_timeout", n, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop(input int exp_d, input logic exp_l, input bit rnd);
        int n;
        logic held;
        logic signed [31:0] hv;
        n = 0;
        held = 1'b0;
        hv = 32'sd0;
        while (n < 200) begin
            out_ready = (rnd && n < 100) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (held) chk("hold_stable", out_data, hv);
                if (out_ready) begin
                    chk("out_data", out_data, exp_d);
                    chk("out_last", out_last, exp_l);
                    @(negedge clk);
                    out_ready = 1'b0;
                    return;
                end
                held = 1'b1;
                hv = out_data;
            end
            @(negedge clk);
            n++;
        end
        chk("pop_timeout", n, 0);
    endtask

    task automatic wait_first(input int exp_lat);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_latency", n, exp_lat);
    endtask

    task automatic run_job(input bit rnd);
        for (int e = 0; e < 8; e++) begin
            push(job_in[e]);
            if (e == 0) begin
                chk("ovf_cleared", ovf, 1'b0);
                chk("busy_loading", busy, 1'b1);
            end
        end
        wait_first(3);
        for (int e = 0; e < 4; e++) pop(job_exp[e], e == 3, rnd);
        chk("ready_after_job", in_ready, 1'b1);
        chk("idle_after_job", busy, 1'b0);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 32'sd0; out_ready = 1'b0;
        d2_in_valid = 1'b0; d2_in_data = 8'sd0; d2_out_ready = 1'b1;
        d3_in_valid = 1'b0; d3_in_data = 16'sd0; d3_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        job_in  = '{1, 2, 3, 4, 5, 6, 7, 8};
        job_exp = '{19, 22, 43, 50};
        run_job(1'b0);
        run_job(1'b1);

        // Abort during COMPUTE of element 1, then a fresh job.
        for (int e = 0; e < 8; e++) push(job_in[e]);
        wait_first(3);
        pop(19, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_data", out_data, 0);
        chk("abort_out_last", out_last, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_output", out_valid, 1'b0);
        job_in  = '{2, 0, 0, 2, 1, -1, 3, 4};
        job_exp = '{2, -2, 6, 8};
        run_job(1'b0);

        // Overflowing job, then identity job that must clear ovf and reproduce B.
        job_in  = '{65536, 65536, 0, 0, 32768, 0, 32768, 0};
`ifdef MULTIPLY_MAT_SAT_EN
        job_exp = '{2147483647, 0, 0, 0};
`else
        job_exp = '{0, 0, 0, 0};
`endif
        run_job(1'b0);
        chk("ovf_sticky", ovf, 1'b1);
        job_in  = '{1, 0, 0, 1, 9, -7, 100, -2147483647 - 1};
        job_exp = '{9, -7, 100, -2147483647 - 1};
        run_job(1'b0);
        chk("ovf_after_identity", ovf, 1'b0);

        // 8-bit overflow: 127*127*2 = 32258.
        for (int e = 0; e < 4; e++) begin
            d2_in_valid = 1'b1;
            d2_in_data  = 8'sd127;
            @(negedge clk);
        end
        d2_in_valid = 1'b0;
        n = 0;
        while (!d2_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ovf8_latency", n, 3);
`ifdef MULTIPLY_MAT_SAT_EN
        chk("ovf8_data", d2_out_data, 127);
`else
        chk("ovf8_data", d2_out_data, 2);
`endif
        chk("ovf8_flag", d2_ovf, 1'b1);
        chk("ovf8_last", d2_out_last, 1'b1);
        @(negedge clk);

        // 1x1x1 with FRAC_BITS=4: -32*3 = -96, >>>4 = -6.
        d3_in_valid = 1'b1;
        d3_in_data  = -16'sd32;
        @(negedge clk);
        d3_in_data  = 16'sd3;
        @(negedge clk);
        d3_in_valid = 1'b0;
        n = 0;
        while (!d3_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("frac_latency", n, 2);
        chk("frac_data", d3_out_data, -6);
        chk("frac_last", d3_out_last, 1'b1);
        chk("frac_ovf", d3_ovf, 1'b0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
